botassium_dpram_ctrl: RTL and testbench
=======================================

# botassium_dpram_ctrl

Parametrised true-dual-port on-chip memory with two Avalon-MM slave ports (s1, s2), registered reads with `readdatavalid`, and a post-reset clear sequencer. It sits on the Nios data bus as the shared scratch/mailbox RAM between the CPU (s1) and a second master (s2). It adds configurable width and depth, same-address collision resolution, and optional byte parity.

## Interface
Parameters:
- `DATA_W`, 32: data width; multiple of 8.
- `DEPTH`, 128: words; power of two, ≥ 4.
- `ADDR_W`, $clog2(DEPTH): word address width.
- `CLEAR_VALUE`, 0: word written to every location by the clear sequencer.
- `WR_PRIO_S1`, 1: 1 = s1 wins a same-address write collision; 0 = s2 wins.

Ports (x ∈ {1,2}):
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  synchronous, active-high.
- `sx_address`  in  ADDR_W  word address.
- `sx_chipselect`  in  1  port select.
- `sx_read`  in  1  read strobe.
- `sx_write`  in  1  write strobe.
- `sx_byteenable`  in  DATA_W/8  byte lanes for writes.
- `sx_writedata`  in  DATA_W  write data.
- `sx_readdata`  out  DATA_W  read data, valid with `sx_readdatavalid`.
- `sx_readdatavalid`  out  1  one-cycle read-response pulse.
- `sx_waitrequest`  out  1  command stall.
- `sx_parity_err`  out  1  parity mismatch on the current response.
- `init_busy`  out  1  high while the clear sequencer runs.

## Operation
- FSM states: CLEAR, RUN.
- `reset` forces CLEAR with clear counter = 0.
- CLEAR: one word per cycle is written with `CLEAR_VALUE` (all bytes, valid parity) at the counter address. After address DEPTH-1 is written, the FSM enters RUN on the next cycle. Duration is exactly DEPTH cycles.
- During CLEAR: `init_busy`=1 and `sx_waitrequest`=1. Commands are held by the master, not dropped.
- RUN: `init_busy`=0 and `sx_waitrequest`=0. Every command is accepted in its issue cycle.
- A command is `sx_chipselect & (sx_read | sx_write)`. `read` and `write` both high counts as a write and produces no response.
- Write: only the lanes enabled by `sx_byteenable` are updated. `byteenable`=0 is a no-op.
- Read: a single `sx_readdatavalid` pulse follows the command.
- Same-address write/write in one cycle: for bytes enabled on both ports the priority port's data is stored (`WR_PRIO_S1`). Bytes enabled on only one port come from that port.
- Same-address read on one port with write on the other: the read returns the post-write word, i.e. enabled lanes forwarded from the writer and the rest from the array.
- Read/read on the same address: both return identical data.
- `reset` asserted mid-operation: pending responses are cancelled (`readdatavalid` 0 next cycle) and CLEAR restarts from address 0.
- Output reset values: `sx_readdata`=0, `sx_readdatavalid`=0, `sx_parity_err`=0, `sx_waitrequest`=1, `init_busy`=1.

## Timing
- Read latency is 1 cycle: command accepted at edge N, then `readdata`/`readdatavalid` are valid after edge N+1.
- Back-to-back reads on every cycle give one response per cycle. Responses are in order.
- Write-to-read on the same port at the next cycle returns the new data; there is no stall.
- `sx_readdata` holds its last value when `readdatavalid` is 0.
- `init_busy` falls on the same edge as `waitrequest`. The first command can be accepted DEPTH+1 cycles after the cycle in which `reset` deasserts.

## Configuration
- `BOTASSIUM_MEM_PARITY_EN` defined:
  - The array stores one even-parity bit per byte, computed on write.
  - On each read response, `sx_parity_err`=1 if any byte of the read word (before forwarding) mismatches its stored parity.
  - Forwarded bytes are never flagged.
  - `sx_parity_err` is valid only with `readdatavalid`.
- Not defined: no parity storage, and `sx_parity_err` is tied to 0.

## Structure
- Package `botassium_mem_pkg` holds:
  - the FSM state enum (`CLEAR`, `RUN`);
  - function `byte_parity(data)` returning DATA_W/8 bits;
  - function `merge_bytes(old, new, be)`.
- Sub-module `botassium_dpram_core`:
  - behavioural two-write, two-read single-clock array with byte-lane write enables and registered read outputs;
  - its word width includes parity bits when enabled.
- The top level owns the clear FSM, collision/forward logic and the Avalon handshakes.

## Test plan
- Release `reset` → `init_busy` and `waitrequest` stay 1 for exactly 128 cycles; then a read of every address on s1 returns 0x00000000.
- s1 writes 0xDEADBEEF at 5 with be=0b0101; s2 reads 5 next cycle → 0x00AD00EF one cycle later, `readdatavalid`=1.
- Same cycle: s1 writes 0x11111111 at 9 (be=0xF), s2 writes 0x22222222 at 9 (be=0xC), `WR_PRIO_S1`=1 → a later read of 9 returns 0x11111111. Repeat with `WR_PRIO_S1`=0 → 0x22221111.
- s1 writes 0xCAFEF00D at 3 while s2 reads 3 in the same cycle → s2 `readdata`=0xCAFEF00D.
- Reads on s2 every cycle to addresses 0..15, then assert `reset` mid-stream → no `readdatavalid` after the reset edge; CLEAR restarts from 0.
- With `BOTASSIUM_MEM_PARITY_EN`, force a parity bit flip at address 7 and read it → `s1_parity_err`=1 together with `readdatavalid`. Without the macro the same stimulus gives `s1_parity_err`=0.

Source files
------------

// File: rtl/botassium_mem_pkg.sv
// botassium_mem_pkg
// Shared types and helpers for the botassium dual-port scratch/mailbox RAM.
//   mem_state_t  : clear-sequencer states (CLEAR, RUN)
//   byte_parity  : even parity per byte lane (bit i covers data[8i+7:8i])
//   merge_bytes  : per-lane select between an old and a new word
// The helpers work on MEM_MAX_W-bit vectors; callers zero-extend narrower
// words and keep the low DATA_W (or DATA_W/8) bits of the result.
package botassium_mem_pkg;

   localparam int MEM_MAX_W = 256;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } mem_state_t;

   function automatic logic [MEM_MAX_W/8-1:0] byte_parity(input logic [MEM_MAX_W-1:0] data);
      logic [MEM_MAX_W/8-1:0] p;
      p = '0;
      for (int i = 0; i < MEM_MAX_W/8; i++) begin
         p[i] = ^data[i*8 +: 8];
      end
      return p;
   endfunction

   function automatic logic [MEM_MAX_W-1:0] merge_bytes(input logic [MEM_MAX_W-1:0]   old_word,
                                                        input logic [MEM_MAX_W-1:0]   new_word,
                                                        input logic [MEM_MAX_W/8-1:0] be);
      logic [MEM_MAX_W-1:0] m;
      m = old_word;
      for (int i = 0; i < MEM_MAX_W/8; i++) begin
         if (be[i]) m[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/botassium_dpram_core.sv
// botassium_dpram_core
// Behavioural single-clock memory with two independent ports, each able to
// write selected lanes or read a whole word per cycle. Read data is
// registered and holds between reads. A word is LANES lanes of LANE_W bits.
// Ports (x = a, b):
//   i_clk, i_rst   : clock, synchronous active-high reset (read registers only)
//   i_addr_x       : word address
//   i_we_x         : per-lane write enables
//   i_wdata_x      : write word
//   i_re_x         : read enable (captures the array word at i_addr_x)
//   o_rdata_x      : registered read word (array contents before this cycle's writes)
module botassium_dpram_core #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [ADDR_W-1:0]         i_addr_a,
   input  logic [LANES-1:0]          i_we_a,
   input  logic [LANES*LANE_W-1:0]   i_wdata_a,
   input  logic                      i_re_a,
   output logic [LANES*LANE_W-1:0]   o_rdata_a,
   input  logic [ADDR_W-1:0]         i_addr_b,
   input  logic [LANES-1:0]          i_we_b,
   input  logic [LANES*LANE_W-1:0]   i_wdata_b,
   input  logic                      i_re_b,
   output logic [LANES*LANE_W-1:0]   o_rdata_b
);

   localparam int WORD_W = LANES * LANE_W;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_q_a_p1;
   logic [WORD_W-1:0] r_q_b_p1;

   // Lanes written by both ports at one address are pre-resolved upstream,
   // so the two writes never overlap here.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (i_we_a[i]) r_mem[i_addr_a][i*LANE_W +: LANE_W] <= i_wdata_a[i*LANE_W +: LANE_W];
         if (i_we_b[i]) r_mem[i_addr_b][i*LANE_W +: LANE_W] <= i_wdata_b[i*LANE_W +: LANE_W];
      end
   end

   // ---- stage p1: registered read ----
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q_a_p1 <= '0;
         r_q_b_p1 <= '0;
      end else begin
         if (i_re_a) r_q_a_p1 <= r_mem[i_addr_a];
         if (i_re_b) r_q_b_p1 <= r_mem[i_addr_b];
      end
   end

   assign o_rdata_a = r_q_a_p1;
   assign o_rdata_b = r_q_b_p1;

endmodule

// File: rtl/botassium_dpram_ctrl.sv
// botassium_dpram_ctrl
// Shared scratch/mailbox RAM with two Avalon-MM slave ports (s1 = CPU,
// s2 = second master). One-cycle registered reads with readdatavalid,
// post-reset clear sequencer, same-address collision resolution.
// Optional byte parity: define BOTASSIUM_MEM_PARITY_EN.
// Ports (x = 1, 2):
//   clk, reset                : single clock, synchronous active-high reset
//   sx_address/chipselect/read/write/byteenable/writedata : command
//   sx_readdata, sx_readdatavalid : read response (one-cycle pulse)
//   sx_waitrequest            : stall, high while clearing
//   sx_parity_err             : parity mismatch on the current response
//   init_busy                 : clear sequencer running
module botassium_dpram_ctrl
   import botassium_mem_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 128,
   parameter int                ADDR_W      = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
   parameter bit                WR_PRIO_S1  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_chipselect,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   output logic                s1_waitrequest,
   output logic                s1_parity_err,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic                s2_chipselect,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W-1:0]   s2_readdata,
   output logic                s2_readdatavalid,
   output logic                s2_waitrequest,
   output logic                s2_parity_err,
   output logic                init_busy
);

   localparam int NB = DATA_W / 8;
`ifdef BOTASSIUM_MEM_PARITY_EN
   localparam int LANE_W = 9;   // {parity, byte}
`else
   localparam int LANE_W = 8;
`endif
   localparam int WORD_W = NB * LANE_W;

   mem_state_t        r_state;
   logic [ADDR_W-1:0] r_clr_addr;

   logic w_run, w_same, w_wr1, w_wr2, w_rd1, w_rd2;
   logic [NB-1:0]     w_be1, w_be2;
   logic [DATA_W-1:0] w_wdat1;
   logic [WORD_W-1:0] w_wword1, w_wword2, w_q1, w_q2;
   logic [DATA_W-1:0] w_rdat1, w_rdat2;
   logic [MEM_MAX_W-1:0] w_merge1_full, w_merge2_full;
   logic w_unused_bits;

   logic              r_s1_vld_p1, r_s2_vld_p1;
   logic [NB-1:0]     r_s1_fwd_be_p1, r_s2_fwd_be_p1;
   logic [DATA_W-1:0] r_s1_fwd_dat_p1, r_s2_fwd_dat_p1;

   // ---- clear sequencer ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= CLEAR;
         r_clr_addr <= '0;
      end else if (r_state == CLEAR) begin
         r_clr_addr <= r_clr_addr + 1'b1;
         if (r_clr_addr == ADDR_W'(DEPTH - 1)) r_state <= RUN;
      end
   end

   assign w_run          = (r_state == RUN);
   assign init_busy      = ~w_run;
   assign s1_waitrequest = ~w_run;
   assign s2_waitrequest = ~w_run;

   // read+write together is a write with no response
   assign w_wr1  = w_run & s1_chipselect & s1_write;
   assign w_wr2  = w_run & s2_chipselect & s2_write;
   assign w_rd1  = w_run & s1_chipselect & s1_read & ~s1_write;
   assign w_rd2  = w_run & s2_chipselect & s2_read & ~s2_write;
   assign w_same = (s1_address == s2_address);

   // Lanes enabled on both ports at one address go to the priority port only.
   always_comb begin
      w_be1 = w_wr1 ? s1_byteenable : '0;
      w_be2 = w_wr2 ? s2_byteenable : '0;
      if (w_wr1 && w_wr2 && w_same) begin
         if (WR_PRIO_S1) w_be2 = w_be2 & ~s1_byteenable;
         else            w_be1 = w_be1 & ~s2_byteenable;
      end
   end

   // Port a doubles as the clear write port while the sequencer runs.
   assign w_wdat1 = w_run ? s1_writedata : CLEAR_VALUE;

`ifdef BOTASSIUM_MEM_PARITY_EN
   logic [MEM_MAX_W/8-1:0] w_pw1_full, w_pw2_full, w_pr1_full, w_pr2_full;
   logic [NB-1:0]          w_rpar1, w_rpar2;
   assign w_pw1_full = byte_parity(MEM_MAX_W'(w_wdat1));
   assign w_pw2_full = byte_parity(MEM_MAX_W'(s2_writedata));
   assign w_pr1_full = byte_parity(MEM_MAX_W'(w_rdat1));
   assign w_pr2_full = byte_parity(MEM_MAX_W'(w_rdat2));
`endif

   for (genvar g = 0; g < NB; g++) begin : g_lane
      assign w_wword1[g*LANE_W +: 8] = w_wdat1[g*8 +: 8];
      assign w_wword2[g*LANE_W +: 8] = s2_writedata[g*8 +: 8];
      assign w_rdat1[g*8 +: 8]       = w_q1[g*LANE_W +: 8];
      assign w_rdat2[g*8 +: 8]       = w_q2[g*LANE_W +: 8];
`ifdef BOTASSIUM_MEM_PARITY_EN
      assign w_wword1[g*LANE_W + 8]  = w_pw1_full[g];
      assign w_wword2[g*LANE_W + 8]  = w_pw2_full[g];
      assign w_rpar1[g]              = w_q1[g*LANE_W + 8];
      assign w_rpar2[g]              = w_q2[g*LANE_W + 8];
`endif
   end

   botassium_dpram_core #(
      .LANES  (NB),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_core (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_addr_a  (w_run ? s1_address : r_clr_addr),
      .i_we_a    (w_run ? w_be1 : {NB{1'b1}}),
      .i_wdata_a (w_wword1),
      .i_re_a    (w_rd1),
      .o_rdata_a (w_q1),
      .i_addr_b  (s2_address),
      .i_we_b    (w_be2),
      .i_wdata_b (w_wword2),
      .i_re_b    (w_rd2),
      .o_rdata_b (w_q2)
   );

   // ---- stage p1: response valid and write-forward capture ----
   // The array returns pre-write data, so a read colliding with the other
   // port's write remembers that writer's lanes and data for the response.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_vld_p1    <= 1'b0;
         r_s2_vld_p1    <= 1'b0;
         r_s1_fwd_be_p1 <= '0;
         r_s2_fwd_be_p1 <= '0;
      end else begin
         r_s1_vld_p1 <= w_rd1;
         r_s2_vld_p1 <= w_rd2;
         if (w_rd1) r_s1_fwd_be_p1 <= (w_wr2 && w_same) ? s2_byteenable : '0;
         if (w_rd2) r_s2_fwd_be_p1 <= (w_wr1 && w_same) ? s1_byteenable : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd1) r_s1_fwd_dat_p1 <= s2_writedata;
      if (w_rd2) r_s2_fwd_dat_p1 <= s1_writedata;
   end

   assign w_merge1_full = merge_bytes(MEM_MAX_W'(w_rdat1), MEM_MAX_W'(r_s1_fwd_dat_p1),
                                      (MEM_MAX_W/8)'(r_s1_fwd_be_p1));
   assign w_merge2_full = merge_bytes(MEM_MAX_W'(w_rdat2), MEM_MAX_W'(r_s2_fwd_dat_p1),
                                      (MEM_MAX_W/8)'(r_s2_fwd_be_p1));

   assign s1_readdata      = w_merge1_full[DATA_W-1:0];
   assign s2_readdata      = w_merge2_full[DATA_W-1:0];
   assign s1_readdatavalid = r_s1_vld_p1;
   assign s2_readdatavalid = r_s2_vld_p1;

`ifdef BOTASSIUM_MEM_PARITY_EN
   // Parity checks the stored word; forwarded lanes are replaced and never flagged.
   assign s1_parity_err = r_s1_vld_p1 & |((w_rpar1 ^ w_pr1_full[NB-1:0]) & ~r_s1_fwd_be_p1);
   assign s2_parity_err = r_s2_vld_p1 & |((w_rpar2 ^ w_pr2_full[NB-1:0]) & ~r_s2_fwd_be_p1);
   assign w_unused_bits = ^{w_merge1_full, w_merge2_full, w_pw1_full, w_pw2_full, w_pr1_full, w_pr2_full};
`else
   assign s1_parity_err = 1'b0;
   assign s2_parity_err = 1'b0;
   assign w_unused_bits = ^{w_merge1_full, w_merge2_full};
`endif

endmodule

// File: tb/tb_botassium_dpram_ctrl.sv
// Testbench for botassium_dpram_ctrl: randomized and directed traffic on both
// ports, expected responses from a word-array reference model queued per port
// and checked by an independent monitor.
module tb_botassium_dpram_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int NB    = DW / 8;
   localparam bit PRIO_S1 = 1'b1;
   localparam logic [DW-1:0] CLR = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [AW-1:0] s1_address, s2_address;
   logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
   logic [NB-1:0] s1_byteenable, s2_byteenable;
   logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
   logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
   logic          s1_parity_err, s2_parity_err, init_busy;

   botassium_dpram_ctrl #(
      .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_VALUE(CLR), .WR_PRIO_S1(PRIO_S1)
   ) dut (
      .clk(clk), .reset(reset),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .s1_waitrequest(s1_waitrequest), .s1_parity_err(s1_parity_err),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
      .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
      .s2_waitrequest(s2_waitrequest), .s2_parity_err(s2_parity_err),
      .init_busy(init_busy)
   );

   typedef struct packed {
      logic          cs, rd, wr;
      logic [AW-1:0] addr;
      logic [NB-1:0] be;
      logic [DW-1:0] wd;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          perr;
      int            cyc;
   } exp_t;

   exp_t q1[$], q2[$];
   logic [DW-1:0] mem_m [DEPTH];
   logic [NB-1:0] bad_m [DEPTH];   // lanes whose stored parity was corrupted
   int n_tests = 0, n_fail = 0, cyc = 0;
   logic [DW-1:0] last1 = '0, last2 = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic cmd_t nop();
      cmd_t c = '0;
      return c;
   endfunction
   function automatic cmd_t rd(input logic [AW-1:0] a);
      cmd_t c = '0;
      c.cs = 1'b1; c.rd = 1'b1; c.addr = a;
      return c;
   endfunction
   function automatic cmd_t wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
      cmd_t c = '0;
      c.cs = 1'b1; c.wr = 1'b1; c.addr = a; c.be = be; c.wd = d;
      return c;
   endfunction

   // Replace the enabled byte lanes of base with those of over.
   function automatic logic [DW-1:0] lanes(input logic [DW-1:0] base, input logic [DW-1:0] over,
                                           input logic [NB-1:0] be);
      logic [DW-1:0] r = base;
      for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = over[i*8 +: 8];
      return r;
   endfunction

   task automatic model_write(input cmd_t c);
      mem_m[c.addr] = lanes(mem_m[c.addr], c.wd, c.be);
      bad_m[c.addr] = bad_m[c.addr] & ~c.be;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = CLR;
         bad_m[i] = '0;
      end
   endtask

   task automatic model_read(input cmd_t r, input cmd_t other, output exp_t e);
      logic [NB-1:0] fwd = '0;
      e.d = mem_m[r.addr];
      if (other.cs && other.wr && other.addr == r.addr) begin
         e.d = lanes(e.d, other.wd, other.be);
         fwd = other.be;
      end
      e.perr = |(bad_m[r.addr] & ~fwd);
      e.cyc  = cyc + 1;
   endtask

   // Present one cycle of commands (called #1 after a rising edge).
   task automatic issue(input cmd_t c1, input cmd_t c2);
      exp_t e;
      s1_address = c1.addr; s1_chipselect = c1.cs; s1_read = c1.rd; s1_write = c1.wr;
      s1_byteenable = c1.be; s1_writedata = c1.wd;
      s2_address = c2.addr; s2_chipselect = c2.cs; s2_read = c2.rd; s2_write = c2.wr;
      s2_byteenable = c2.be; s2_writedata = c2.wd;
      if (c1.cs && c1.rd && !c1.wr) begin model_read(c1, c2, e); q1.push_back(e); end
      if (c2.cs && c2.rd && !c2.wr) begin model_read(c2, c1, e); q2.push_back(e); end
      if (PRIO_S1) begin
         if (c2.cs && c2.wr) model_write(c2);
         if (c1.cs && c1.wr) model_write(c1);
      end else begin
         if (c1.cs && c1.wr) model_write(c1);
         if (c2.cs && c2.wr) model_write(c2);
      end
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Count cycles with init_busy high after reset release; must be exactly DEPTH.
   task automatic wait_clear(input string name);
      int n = 0;
      bit done = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         check({name, "_wait_eq_busy"}, {31'b0, s2_waitrequest}, {31'b0, init_busy});
         if (init_busy) n++;
         else done = 1;
      end
      check({name, "_busy_cycles"}, n, DEPTH);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_s1_rdata"}, s1_readdata, '0);
      check({name, "_s2_rdata"}, s2_readdata, '0);
      check({name, "_s1_rvalid"}, {31'b0, s1_readdatavalid}, 32'd0);
      check({name, "_s2_rvalid"}, {31'b0, s2_readdatavalid}, 32'd0);
      check({name, "_s1_perr"}, {31'b0, s1_parity_err}, 32'd0);
      check({name, "_s1_waitreq"}, {31'b0, s1_waitrequest}, 32'd1);
      check({name, "_busy"}, {31'b0, init_busy}, 32'd1);
   endtask

   // Monitor: compares every response against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (s1_readdatavalid) begin
         if (q1.size() == 0) begin
            check("s1_unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("s1_rdata", s1_readdata, e.d);
            check("s1_perr", {31'b0, s1_parity_err}, {31'b0, e.perr});
            check("s1_latency", cyc, e.cyc);
         end
         last1 = s1_readdata;
      end else begin
         check("s1_hold", s1_readdata, last1);
      end
      if (s2_readdatavalid) begin
         if (q2.size() == 0) begin
            check("s2_unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            e = q2.pop_front();
            check("s2_rdata", s2_readdata, e.d);
            check("s2_perr", {31'b0, s2_parity_err}, {31'b0, e.perr});
            check("s2_latency", cyc, e.cyc);
         end
         last2 = s2_readdata;
      end else begin
         check("s2_hold", s2_readdata, last2);
      end
      if (reset) begin
         last1 = '0;
         last2 = '0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t c1, c2;
      reset = 1'b1;
      s1_address = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_byteenable = '0; s1_writedata = '0;
      s2_address = '0; s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_byteenable = '0; s2_writedata = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      wait_clear("clear1");

      // every address reads back as the clear value, back-to-back on s1
      for (int a = 0; a < DEPTH; a++) issue(rd(AW'(a)), nop());

      // partial write on s1, s2 reads it the next cycle
      issue(wr(5, 4'b0101, 32'hDEADBEEF), nop());
      issue(nop(), rd(5));
      // write/write collision at one address
      issue(wr(9, 4'hF, 32'h11111111), wr(9, 4'hC, 32'h22222222));
      issue(rd(9), nop());
      // read/read same address
      issue(rd(9), rd(9));
      // read on s2 sees s1's same-cycle write
      issue(wr(3, 4'hF, 32'hCAFEF00D), rd(3));
      // and the mirror case with partial lanes
      issue(rd(3), wr(3, 4'b0010, 32'h0000AA00));
      // write then read on the same port, next cycle
      issue(wr(20, 4'hF, 32'h12345678), nop());
      issue(rd(20), nop());
      // byteenable 0 is a no-op; read+write together is a write
      issue(wr(20, 4'h0, 32'hFFFFFFFF), nop());
      c1 = wr(20, 4'b1000, 32'hAB000000); c1.rd = 1'b1;
      issue(c1, nop());
      issue(rd(20), nop());
      // corrupted parity at address 7 (only meaningful with parity storage)
`ifdef BOTASSIUM_MEM_PARITY_EN
      dut.u_core.r_mem[7][8] = ~dut.u_core.r_mem[7][8];
      bad_m[7][0] = 1'b1;
`endif
      issue(rd(7), nop());
      issue(nop(), wr(7, 4'b0001, 32'h0000005A));
      issue(rd(7), nop());
      issue(nop(), nop());

      // randomized traffic on a small address window to force collisions
      for (int i = 0; i < 400; i++) begin
         c1 = nop(); c2 = nop();
         c1.cs = ($urandom_range(3) != 0); c1.rd = $urandom_range(1); c1.wr = ($urandom_range(2) == 0);
         c1.addr = AW'($urandom_range(15)); c1.be = NB'($urandom); c1.wd = $urandom;
         c2.cs = ($urandom_range(3) != 0); c2.rd = $urandom_range(1); c2.wr = ($urandom_range(2) == 0);
         c2.addr = AW'($urandom_range(15)); c2.be = NB'($urandom); c2.wd = $urandom;
         issue(c1, c2);
      end

      // streaming reads on s2, then reset mid-stream
      for (int a = 0; a < 16; a++) issue(nop(), rd(AW'(a)));
      s2_chipselect = 0; s2_read = 0;
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      reset = 1'b0;
      model_clear();
      wait_clear("clear2");

      for (int a = 0; a < 16; a++) issue(rd(AW'(a)), rd(AW'(15 - a)));
      issue(nop(), nop());
      issue(nop(), nop());
      check("s1_queue_drained", q1.size(), 0);
      check("s2_queue_drained", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
